// File: rtl/onehot_codec_pipe.sv
// Registered binary<->one-hot codec behind a single valid/ready output stage.
// Define ONEHOT_CODEC_ERR_CNT_EN to add the saturating err_cnt/err_cnt_clr status counter.
module onehot_codec_pipe #(
  parameter int BIN_W     = 4,
  parameter int ONE_HOT_W = 16,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [ONE_HOT_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ONE_HOT_W-1:0] out_data,
  output logic                 out_err
`ifdef ONEHOT_CODEC_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]     err_cnt,
  input  logic                 err_cnt_clr
`endif
);

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  if (BIN_W < 1 || BIN_W > 8 || ONE_HOT_W < 2 || ONE_HOT_W > (1 << BIN_W) ||
      ONE_HOT_W < BIN_W || CNT_W < 1) begin : g_param_check
    $error("onehot_codec_pipe: illegal parameter combination");
  end

  logic                 state_q, state_d;
  logic [ONE_HOT_W-1:0] data_q, data_d;
  logic                 err_q, err_d;

  logic [BIN_W-1:0]     idx;
  logic [ONE_HOT_W-1:0] enc_vec;
  logic                 enc_err;
  logic [BIN_W-1:0]     dec_idx;
  logic                 dec_found;
  logic                 dec_multi;
  logic [ONE_HOT_W-1:0] res_data;
  logic                 res_err;
  logic                 load;

  assign idx = in_data[BIN_W-1:0];

  always_comb begin
    enc_vec = '0;
    enc_err = 1'b1;
    for (int unsigned i = 0; i < ONE_HOT_W; i++) begin
      if (32'(idx) == i) begin
        enc_vec[i] = 1'b1;
        enc_err    = 1'b0;
      end
    end
  end

  // Lowest set bit wins; any further set bit marks the code as illegal.
  always_comb begin
    dec_idx   = '0;
    dec_found = 1'b0;
    dec_multi = 1'b0;
    for (int unsigned i = 0; i < ONE_HOT_W; i++) begin
      if (in_data[i]) begin
        if (dec_found) begin
          dec_multi = 1'b1;
        end else begin
          dec_idx   = BIN_W'(i);
          dec_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    if (in_mode) begin
      res_data = ONE_HOT_W'(dec_idx);
      res_err  = !dec_found || dec_multi;
    end else begin
      res_data = enc_vec;
      res_err  = enc_err;
    end
  end

  assign in_ready  = (state_q == EMPTY) || out_ready;
  assign load      = in_valid && in_ready;
  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_err   = err_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    err_d   = err_q;
    if (load) begin
      state_d = FULL;
      data_d  = res_data;
      err_d   = res_err;
    end else if (out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

`ifdef ONEHOT_CODEC_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_inc;

  assign err_inc = load && res_err;
  assign err_cnt = err_cnt_q;

  // A clear coinciding with a counted error leaves exactly that one error.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_cnt_clr) begin
      err_cnt_d = err_inc ? CNT_W'(1) : '0;
    end else if (err_inc && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end
`endif

endmodule
